bus_mem_responder: RTL and testbench

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

---
 rtl/bus_mem_responder.sv | 115 +++++++++++
 tb/tb_bus_mem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: single-outstanding bus-to-memory responder with byte-lane steering.
// Optional ack timeout enabled by defining BUS_RESP_TIMEOUT_EN.
module bus_mem_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic [31:0] i_addr,
    input  logic        i_we,
    input  logic        i_le,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_ctrl,
    output logic [31:0] o_rdata,
    output logic        o_busy,
    output logic        o_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_t;
    state_t      state;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        uns;
    logic        take;
    logic        misaligned;
    logic [3:0]  strb;
    logic [31:0] lane_wdata;
    logic [31:0] shifted;
    logic [31:0] load_val;
`ifdef BUS_RESP_TIMEOUT_EN
    logic [7:0]  cnt;
`endif

    assign take       = i_we | i_le;
    assign misaligned = (i_ctrl[1:0] == 2'd3) |
                        (i_ctrl[1:0] == 2'd2 && i_addr[1:0] != 2'd0) |
                        (i_ctrl[1:0] == 2'd1 && i_addr[0]);
    assign strb       = i_ctrl[1:0] == 2'd0 ? 4'b0001 << i_addr[1:0] :
                        i_ctrl[1:0] == 2'd1 ? 4'b0011 << i_addr[1:0] : 4'hF;
    assign lane_wdata = i_ctrl[1:0] == 2'd0 ? {4{i_wdata[7:0]}} :
                        i_ctrl[1:0] == 2'd1 ? {2{i_wdata[15:0]}} : i_wdata;
    assign shifted    = i_mem_rdata >> {off, 3'b000};
    assign load_val   = size == 2'd0 ? {{24{~uns & shifted[7]}}, shifted[7:0]} :
                        size == 2'd1 ? {{16{~uns & shifted[15]}}, shifted[15:0]} : i_mem_rdata;
    // Busy is combinational so the requester sees it in the strobe cycle itself.
    assign o_busy     = RST_X && (state == ACCESS || (state == IDLE && take));

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state       <= IDLE;
            off         <= 2'd0;
            size        <= 2'd0;
            uns         <= 1'b0;
            o_rdata     <= 32'd0;
            o_err       <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_wdata <= 32'd0;
            o_mem_wstrb <= 4'd0;
`ifdef BUS_RESP_TIMEOUT_EN
            cnt         <= 8'd0;
`endif
        end else begin
            o_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (take && misaligned) begin
                        state <= ERR;
                        o_err <= 1'b1;
                    end else if (take) begin
                        state       <= ACCESS;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= i_we;
                        o_mem_addr  <= {i_addr[31:2], 2'b00};
                        o_mem_wdata <= lane_wdata;
                        o_mem_wstrb <= i_we ? strb : 4'h0;
                        off         <= i_addr[1:0];
                        size        <= i_ctrl[1:0];
                        uns         <= i_ctrl[2];
`ifdef BUS_RESP_TIMEOUT_EN
                        cnt         <= 8'd0;
`endif
                    end
                end
                ACCESS: begin
                    if (i_mem_ack) begin
                        state     <= IDLE;
                        o_mem_req <= 1'b0;
                        if (!o_mem_we)
                            o_rdata <= load_val;
                    end
`ifdef BUS_RESP_TIMEOUT_EN
                    else begin
                        cnt <= cnt + 8'd1;
                        if (cnt + 8'd1 == 8'(TIMEOUT_CYCLES)) begin
                            state     <= ERR;
                            o_err     <= 1'b1;
                            o_mem_req <= 1'b0;
                            if (!o_mem_we)
                                o_rdata <= 32'hDEADBEEF;
                        end
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_mem_responder.sv
// tb_bus_mem_responder: scoreboard bench for bus_mem_responder.
// Timeout scenario runs only when BUS_RESP_TIMEOUT_EN is defined.
module tb_bus_mem_responder;
    logic        CLK = 1'b0;
    logic        RST_X = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_we = 1'b0;
    logic        i_le = 1'b0;
    logic [31:0] i_wdata = '0;
    logic [2:0]  i_ctrl = '0;
    logic [31:0] o_rdata;
    logic        o_busy;
    logic        o_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

    req_t        req_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] last_rdata = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    bus_mem_responder #(.TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .RST_X(RST_X), .i_addr(i_addr), .i_we(i_we), .i_le(i_le),
        .i_wdata(i_wdata), .i_ctrl(i_ctrl), .o_rdata(o_rdata), .o_busy(o_busy),
        .o_err(o_err), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [31:0] w, input int a, input logic [2:0] c);
        logic [31:0] r;
        int nb;
        nb = c[1:0] == 2'd0 ? 1 : c[1:0] == 2'd1 ? 2 : 4;
        r = '0;
        for (int i = 0; i < nb; i++) r[i*8 +: 8] = w[(a+i)*8 +: 8];
        if (!c[2] && r[nb*8-1])
            for (int i = nb*8; i < 32; i++) r[i] = 1'b1;
        return r;
    endfunction

    // One bus transaction: strobe at cycle 0, ack at cycle k, expectations via the queues.
    task automatic run(input logic we, input logic le, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] ctrl, input int k, input logic [31:0] mrd, input logic again);
        req_t e, g;
        logic [31:0] mask, exp_rd;
        int nb, a;
        logic bad;
        nb  = ctrl[1:0] == 2'd0 ? 1 : ctrl[1:0] == 2'd1 ? 2 : 4;
        a   = int'(addr[1:0]);
        bad = ctrl[1:0] == 2'd3 || (a % nb) != 0;
        if (!bad) begin
            e = '0;
            e.we = we;
            e.addr = {addr[31:2], 2'b00};
            for (int i = 0; i < nb; i++) begin
                e.strb[a+i] = 1'b1;
                e.wdata[(a+i)*8 +: 8] = wdata[i*8 +: 8];
            end
            req_q.push_back(e);
        end
        exp_q.push_back(bad || we ? last_rdata : exp_load(mrd, a, ctrl));
        @(posedge CLK); #1;
        i_addr = addr; i_we = we; i_le = le; i_wdata = wdata; i_ctrl = ctrl;
        @(negedge CLK);
        check("busy_strobe", {31'd0, o_busy}, 32'd1);
        @(posedge CLK); #1;
        i_we = again; i_le = 1'b0; i_addr = ~addr; i_wdata = ~wdata; i_ctrl = 3'd2;
        if (bad) begin
            @(negedge CLK);
            check("err_pulse", {31'd0, o_err}, 32'd1);
            check("busy_err", {31'd0, o_busy}, 32'd0);
            check("req_err", {31'd0, o_mem_req}, 32'd0);
            @(posedge CLK); #1;
            i_we = 1'b0;
        end else begin
            for (int c = 1; c <= k; c++) begin
                if (c == k) begin
                    i_mem_ack = 1'b1;
                    i_mem_rdata = mrd;
                end
                @(negedge CLK);
                check("req_hold", {31'd0, o_mem_req}, 32'd1);
                check("busy_acc", {31'd0, o_busy}, 32'd1);
                if (c == 1) begin
                    g = req_q.pop_front();
                    check("mem_we", {31'd0, o_mem_we}, {31'd0, g.we});
                    check("mem_addr", o_mem_addr, g.addr);
                    if (g.we) begin
                        for (int i = 0; i < 4; i++) mask[i*8 +: 8] = {8{g.strb[i]}};
                        check("mem_wstrb", {28'd0, o_mem_wstrb}, {28'd0, g.strb});
                        check("mem_wdata", o_mem_wdata & mask, g.wdata);
                    end
                end
                @(posedge CLK); #1;
                i_we = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = 32'hA5A5_5A5A;
            end
        end
        @(negedge CLK);
        exp_rd = exp_q.pop_front();
        check("rdata", o_rdata, exp_rd);
        check("busy_done", {31'd0, o_busy}, 32'd0);
        check("req_done", {31'd0, o_mem_req}, 32'd0);
        check("err_done", {31'd0, o_err}, 32'd0);
        last_rdata = exp_rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_we = 1'b1;
        #12;
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_err", {31'd0, o_err}, 32'd0);
        check("rst_req", {31'd0, o_mem_req}, 32'd0);
        check("rst_we", {31'd0, o_mem_we}, 32'd0);
        check("rst_wstrb", {28'd0, o_mem_wstrb}, 32'd0);
        check("rst_addr", o_mem_addr, 32'd0);
        check("rst_wdata", o_mem_wdata, 32'd0);
        i_we = 1'b0;
        @(posedge CLK); #1;
        RST_X = 1'b1;

        run(1'b0, 1'b1, 32'h8000_0004, 32'h0, 3'd2, 1, 32'h1122_3344, 1'b0);
        run(1'b0, 1'b1, 32'h8000_0003, 32'h0, 3'd0, 2, 32'h80FF_FFFF, 1'b0);
        run(1'b0, 1'b1, 32'h8000_0003, 32'h0, 3'd4, 1, 32'h80FF_FFFF, 1'b0);
        run(1'b1, 1'b0, 32'h8000_0002, 32'h0000_ABCD, 3'd1, 2, 32'hFFFF_FFFF, 1'b0);
        run(1'b0, 1'b1, 32'h8000_0001, 32'h0, 3'd2, 1, 32'h0, 1'b0);
        run(1'b0, 1'b1, 32'h8000_0003, 32'h0, 3'd1, 1, 32'h0, 1'b1);
        run(1'b0, 1'b1, 32'h8000_0000, 32'h0, 3'd3, 1, 32'h0, 1'b0);
        run(1'b1, 1'b1, 32'h8000_0008, 32'hCAFE_F00D, 3'd2, 3, 32'h0, 1'b1);
        run(1'b0, 1'b1, 32'h8000_0002, 32'h0, 3'd1, 3, 32'h8001_0000, 1'b0);
        run(1'b0, 1'b1, 32'h8000_0000, 32'h0, 3'd5, 1, 32'h1234_F678, 1'b0);
        run(1'b1, 1'b0, 32'h8000_0001, 32'h0000_005A, 3'd0, 1, 32'h0, 1'b0);
        run(1'b0, 1'b1, 32'h8000_0001, 32'h0, 3'd0, 2, 32'h1122_3344, 1'b0);

        // Ack in IDLE must not disturb anything.
        @(posedge CLK); #1;
        i_mem_ack = 1'b1; i_mem_rdata = 32'h1234_5678;
        @(negedge CLK);
        check("idle_ack_busy", {31'd0, o_busy}, 32'd0);
        @(posedge CLK); #1;
        i_mem_ack = 1'b0;
        @(negedge CLK);
        check("idle_ack_rdata", o_rdata, last_rdata);
        check("idle_ack_req", {31'd0, o_mem_req}, 32'd0);

        // Reset mid-access abandons the transaction; late ack is ignored.
        @(posedge CLK); #1;
        i_addr = 32'h8000_0010; i_le = 1'b1; i_ctrl = 3'd2;
        @(posedge CLK); #1;
        i_le = 1'b0;
        RST_X = 1'b0;
        #1;
        check("midrst_req", {31'd0, o_mem_req}, 32'd0);
        check("midrst_rdata", o_rdata, 32'd0);
        check("midrst_busy", {31'd0, o_busy}, 32'd0);
        @(posedge CLK); #1;
        RST_X = 1'b1;
        i_mem_ack = 1'b1; i_mem_rdata = 32'h7777_7777;
        @(posedge CLK); #1;
        i_mem_ack = 1'b0;
        @(negedge CLK);
        check("late_ack_rdata", o_rdata, 32'd0);
        check("late_ack_req", {31'd0, o_mem_req}, 32'd0);
        last_rdata = 32'd0;

`ifdef BUS_RESP_TIMEOUT_EN
        @(posedge CLK); #1;
        i_addr = 32'h8000_0020; i_le = 1'b1; i_ctrl = 3'd2;
        @(posedge CLK); #1;
        i_le = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            check("tmo_req_hold", {31'd0, o_mem_req}, 32'd1);
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        check("tmo_req_drop", {31'd0, o_mem_req}, 32'd0);
        check("tmo_err", {31'd0, o_err}, 32'd1);
        check("tmo_busy", {31'd0, o_busy}, 32'd0);
        check("tmo_rdata", o_rdata, 32'hDEAD_BEEF);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("tmo_err_clear", {31'd0, o_err}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
